// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// master drives Start/A/B; slave returns Diff/Borrow/Busy/Done.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, A, B,
        input  Diff, Borrow, Busy, Done
    );

    modport slave (
        input  Start, A, B,
        output Diff, Borrow, Busy, Done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B, one bit per clock, LSB first.
// Ports: Clk, Reset (sync, active-high), bus (slave: Start/A/B in; Diff/Borrow/Busy/Done out).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic                Clk,
    input logic                Reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // Result fills from the MSB so it is aligned after WIDTH shifts.
        res_shift = (res_q >> 1) | {d_bit, {(WIDTH-1){1'b0}}};

        case (state_q)
            IDLE, DONE: begin
                // DONE falls back to IDLE unless a new request arrives.
                state_d = IDLE;
                if (bus.Start) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = res_shift;
                    borrow_d = br_nxt;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
    assign bus.Busy   = (state_q == RUN);
    assign bus.Done   = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: vector table, exhaustive sweep,
// randomized ops with input noise, back-to-back, abort and WIDTH=8 cases.
module tb_serial_subtractor;
    logic Clk;
    logic Reset;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(4)) u4 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus4.slave)
    );

    serial_subtractor #(.WIDTH(8)) u8 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus8.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests;
    int fails;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       br;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on unsigned operands.
    function automatic logic [3:0] ref_diff(input int a, input int b);
        return 4'((a + 16 - b) % 16);
    endfunction

    function automatic logic ref_borrow(input int a, input int b);
        return (a < b);
    endfunction

    // Issue one request from a negedge; return timing and result.
    task automatic op(input logic [3:0] a, input logic [3:0] b,
                      input bit noise, output int bc, output bit gd,
                      output logic [3:0] d, output logic bo,
                      output bit held);
        logic [3:0] prev;
        prev = bus4.Diff;
        bus4.Start = 1'b1;
        bus4.A = a;
        bus4.B = b;
        @(negedge Clk);
        bus4.Start = 1'b0;
        bc = 0;
        gd = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus4.Done) begin
                gd = 1'b1;
                break;
            end
            if (bus4.Busy) bc++;
            if (bus4.Diff !== prev) held = 1'b0;
            if (noise) begin
                bus4.Start = 1'($urandom);
                bus4.A = 4'($urandom);
                bus4.B = 4'($urandom);
            end
            @(negedge Clk);
        end
        bus4.Start = 1'b0;
        d = bus4.Diff;
        bo = bus4.Borrow;
    endtask

    task automatic run_check(input string name, input logic [3:0] a,
                             input logic [3:0] b, input bit noise,
                             input logic [3:0] ed, input logic eb);
        int bc;
        bit gd;
        bit held;
        logic [3:0] d;
        logic bo;
        op(a, b, noise, bc, gd, d, bo, held);
        check({name, "_done"}, 32'(gd), 32'd1);
        check({name, "_busy_cycles"}, 32'(bc), 32'd4);
        check({name, "_diff"}, 32'(d), 32'(ed));
        check({name, "_borrow"}, 32'(bo), 32'(eb));
        check({name, "_diff_held"}, 32'(held), 32'd1);
        @(negedge Clk);
        check({name, "_idle_after"}, {30'd0, bus4.Busy, bus4.Done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_k;
        int gap_k;
        int dcount;
        logic [3:0] r1d, r2d;
        logic r1b, r2b;
        int bc8;
        bit gd8;

        tests = 0;
        fails = 0;
        vecs[0] = '{4'd7,  4'd3,  4'd4,  1'b0};
        vecs[1] = '{4'd3,  4'd7,  4'd12, 1'b1};
        vecs[2] = '{4'd0,  4'd15, 4'd1,  1'b1};
        vecs[3] = '{4'd15, 4'd15, 4'd0,  1'b0};
        vecs[4] = '{4'd9,  4'd0,  4'd9,  1'b0};

        Reset = 1'b1;
        bus4.Start = 1'b0;
        bus4.A = '0;
        bus4.B = '0;
        bus8.Start = 1'b0;
        bus8.A = '0;
        bus8.B = '0;
        repeat (2) @(negedge Clk);
        // Reset dominates a concurrent Start.
        bus4.Start = 1'b1;
        @(negedge Clk);
        bus4.Start = 1'b0;
        Reset = 1'b0;
        check("reset_busy", 32'(bus4.Busy), 32'd0);
        check("reset_done", 32'(bus4.Done), 32'd0);
        check("reset_diff", 32'(bus4.Diff), 32'd0);
        check("reset_borrow", 32'(bus4.Borrow), 32'd0);
        @(negedge Clk);
        check("reset_start_ignored", 32'(bus4.Busy), 32'd0);

        for (int i = 0; i < 5; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0,
                      vecs[i].d, vecs[i].br);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_check($sformatf("sweep_%0d_%0d", a, b), 4'(a), 4'(b),
                          1'b0, ref_diff(a, b), ref_borrow(a, b));

        for (int i = 0; i < 40; i++) begin
            int ra, rb;
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            run_check($sformatf("rand%0d", i), 4'(ra), 4'(rb), 1'b1,
                      ref_diff(ra, rb), ref_borrow(ra, rb));
        end

        // Start held high: 5-2 then 2-5 back to back.
        bus4.Start = 1'b1;
        bus4.A = 4'd5;
        bus4.B = 4'd2;
        first_k = -1;
        gap_k = -1;
        dcount = 0;
        r1d = '0;
        r2d = '0;
        r1b = 1'b0;
        r2b = 1'b0;
        for (int k = 1; k <= 20 && dcount < 2; k++) begin
            @(negedge Clk);
            if (bus4.Done) begin
                if (dcount == 0) begin
                    first_k = k;
                    r1d = bus4.Diff;
                    r1b = bus4.Borrow;
                    bus4.A = 4'd2;
                    bus4.B = 4'd5;
                end else begin
                    gap_k = k - first_k;
                    r2d = bus4.Diff;
                    r2b = bus4.Borrow;
                    bus4.Start = 1'b0;
                end
                dcount++;
            end
        end
        bus4.Start = 1'b0;
        check("b2b_done_count", 32'(dcount), 32'd2);
        check("b2b_first_latency", 32'(first_k), 32'd5);
        check("b2b_period", 32'(gap_k), 32'd5);
        check("b2b_r1_diff", 32'(r1d), 32'd3);
        check("b2b_r1_borrow", 32'(r1b), 32'd0);
        check("b2b_r2_diff", 32'(r2d), 32'd13);
        check("b2b_r2_borrow", 32'(r2b), 32'd1);
        @(negedge Clk);
        check("b2b_idle_after", {30'd0, bus4.Busy, bus4.Done}, 32'd0);

        // Leave a nonzero result with borrow set before the abort.
        run_check("pre_abort", 4'd3, 4'd7, 1'b0, 4'd12, 1'b1);
        bus4.Start = 1'b1;
        bus4.A = 4'd12;
        bus4.B = 4'd3;
        @(negedge Clk);
        bus4.Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", 32'(bus4.Busy), 32'd0);
        check("abort_diff", 32'(bus4.Diff), 32'd0);
        check("abort_borrow", 32'(bus4.Borrow), 32'd0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus4.Done) n++;
            @(negedge Clk);
        end
        check("abort_no_done", 32'(n), 32'd0);
        run_check("post_abort", 4'd10, 4'd4, 1'b0, 4'd6, 1'b0);

        // WIDTH=8: 0x80 - 0x81.
        bus8.Start = 1'b1;
        bus8.A = 8'h80;
        bus8.B = 8'h81;
        @(negedge Clk);
        bus8.Start = 1'b0;
        bc8 = 0;
        gd8 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus8.Done) begin
                gd8 = 1'b1;
                break;
            end
            if (bus8.Busy) bc8++;
            @(negedge Clk);
        end
        check("w8_done", 32'(gd8), 32'd1);
        check("w8_busy_cycles", 32'(bc8), 32'd8);
        check("w8_diff", 32'(bus8.Diff), 32'hFF);
        check("w8_borrow", 32'(bus8.Borrow), 32'd1);
        @(negedge Clk);
        check("w8_idle_after", {30'd0, bus8.Busy, bus8.Done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
